// File: rtl/pipe_pal_arb_if.sv
// Bundle of requester-side and datapath-side signals around the shared pipe_pal input.
// The master modport drives requests and datapath ready; the slave modport is the arbiter.
interface pipe_pal_arb_if #(
   parameter int W_DATA = 32,
   parameter int N_REQ  = 4,
   parameter int W_ID   = 2,
   parameter int W_CNT  = 8
);
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ*W_DATA-1:0] i_req_data;
   logic [N_REQ-1:0]        i_req_last;
   logic [N_REQ-1:0]        o_req_ready;
   logic                    o_valid;
   logic [W_DATA-1:0]       o_data;
   logic                    o_last;
   logic [W_ID-1:0]         o_id;
   logic                    i_ready;
   logic                    o_busy;
   logic [W_CNT-1:0]        o_beats;

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_ready,
      input  o_req_ready, o_valid, o_data, o_last, o_id, o_busy, o_beats
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_ready,
      output o_req_ready, o_valid, o_data, o_last, o_id, o_busy, o_beats
   );
endinterface

// File: rtl/pipe_pal_arb.sv
// Round-robin burst arbiter: locks one requester for a whole last-terminated burst,
// passes its beats straight through to the datapath and rotates priority afterwards.
module pipe_pal_arb #(
   parameter int W_DATA = 32,
   parameter int N_REQ  = 4,
   parameter int W_ID   = 2,
   parameter int W_CNT  = 8
) (
   input logic           i_clk,
   input logic           i_reset,
   pipe_pal_arb_if.slave bus
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_q, state_d;
   logic [W_ID-1:0]   ptr_q, ptr_d;
   logic [W_ID-1:0]   grant_q, grant_d;
   logic [W_CNT-1:0]  beats_q, beats_d;

   logic [N_REQ-1:0]  maskedValid;
   logic              pickFound;
   logic [W_ID-1:0]   pickIdx;
   logic              gValid;
   logic              gLast;
   logic [W_DATA-1:0] gData;

   // Lowest request at or above the pointer wins; otherwise wrap to the lowest request overall.
   always_comb begin
      maskedValid = bus.i_req_valid & ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
      pickFound   = |bus.i_req_valid;
      pickIdx     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.i_req_valid[k]) pickIdx = W_ID'(k);
      end
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (maskedValid[k]) pickIdx = W_ID'(k);
      end
   end

   // Select the granted lane; other lanes never reach the datapath.
   always_comb begin
      gValid = 1'b0;
      gLast  = 1'b0;
      gData  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_q == W_ID'(k)) begin
            gValid = bus.i_req_valid[k];
            gLast  = bus.i_req_last[k];
            gData  = bus.i_req_data[k*W_DATA +: W_DATA];
         end
      end
   end

   // Next-state and pass-through outputs; IDLE forwards nothing.
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      grant_d         = grant_q;
      beats_d         = beats_q;
      bus.o_valid     = 1'b0;
      bus.o_data      = '0;
      bus.o_last      = 1'b0;
      bus.o_req_ready = '0;
      case (state_q)
         IDLE: begin
            if (pickFound) begin
               grant_d = pickIdx;
               beats_d = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            bus.o_valid     = gValid;
            bus.o_data      = gValid ? gData : '0;
            bus.o_last      = gLast;
            bus.o_req_ready = N_REQ'(bus.i_ready) << grant_q;
            if (gValid && bus.i_ready) begin
               beats_d = (beats_q == '1) ? beats_q : beats_q + W_CNT'(1);
               if (gLast) begin
                  state_d = IDLE;
                  ptr_d   = (grant_q == W_ID'(N_REQ - 1)) ? '0 : grant_q + W_ID'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         beats_q <= beats_d;
      end
   end

   assign bus.o_id    = grant_q;
   assign bus.o_busy  = (state_q == BURST);
   assign bus.o_beats = beats_q;

endmodule

// File: tb/tb_pipe_pal_arb.sv
// Bench for pipe_pal_arb: directed scenarios plus random traffic against a burst-level
// reference model, and a narrow N_REQ=3/W_CNT=2 instance for saturation and wrap.
module tb_pipe_pal_arb;

   logic i_clk;
   logic i_reset;
   int   total;
   int   bad;

   // Reference model state: whether a burst is granted, who holds it, rotation pointer, beats.
   bit   mBusy;
   int   mId;
   int   mPtr;
   int   mBeats;

   pipe_pal_arb_if #(.W_DATA(32), .N_REQ(4), .W_ID(2), .W_CNT(8)) ifA ();
   pipe_pal_arb_if #(.W_DATA(8),  .N_REQ(3), .W_ID(2), .W_CNT(2)) ifB ();

   pipe_pal_arb #(.W_DATA(32), .N_REQ(4), .W_ID(2), .W_CNT(8)) dutA (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (ifA.slave)
   );

   pipe_pal_arb #(.W_DATA(8), .N_REQ(3), .W_ID(2), .W_CNT(2)) dutB (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (ifB.slave)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy  = 1'b0;
      mId    = 0;
      mPtr   = 0;
      mBeats = 0;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_valid", 64'(ifA.o_valid), 64'd0);
      checkOutput("rst_data",  64'(ifA.o_data), 64'd0);
      checkOutput("rst_last",  64'(ifA.o_last), 64'd0);
      checkOutput("rst_ready", 64'(ifA.o_req_ready), 64'd0);
      checkOutput("rst_id",    64'(ifA.o_id), 64'd0);
      checkOutput("rst_busy",  64'(ifA.o_busy), 64'd0);
      checkOutput("rst_beats", 64'(ifA.o_beats), 64'd0);
   endtask

   task automatic doReset();
      i_reset = 1'b1;
      #1;
      checkResetValues();
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      modelReset();
   endtask

   // Compare every output against the model for the current inputs, then advance the model.
   task automatic modelCheck();
      logic [3:0]  v;
      logic [3:0]  l;
      logic        r;
      logic        expValid;
      logic [31:0] expData;
      logic        expLast;
      logic [3:0]  expReady;
      v = ifA.i_req_valid;
      l = ifA.i_req_last;
      r = ifA.i_ready;
      expValid = mBusy ? v[mId] : 1'b0;
      expData  = expValid ? ifA.i_req_data[mId*32 +: 32] : 32'd0;
      expLast  = mBusy ? l[mId] : 1'b0;
      expReady = mBusy ? (4'(r) << mId) : 4'd0;
      checkOutput("valid", 64'(ifA.o_valid), 64'(expValid));
      checkOutput("data",  64'(ifA.o_data), 64'(expData));
      checkOutput("last",  64'(ifA.o_last), 64'(expLast));
      checkOutput("ready", 64'(ifA.o_req_ready), 64'(expReady));
      checkOutput("id",    64'(ifA.o_id), 64'(mId));
      checkOutput("busy",  64'(ifA.o_busy), 64'(mBusy));
      checkOutput("beats", 64'(ifA.o_beats), 64'(mBeats));
      if (!mBusy) begin
         for (int k = 0; k < 4; k++) begin
            if (!mBusy && v[(mPtr + k) % 4]) begin
               mBusy  = 1'b1;
               mId    = (mPtr + k) % 4;
               mBeats = 0;
            end
         end
      end else if (expValid && r) begin
         mBeats = (mBeats < 255) ? mBeats + 1 : 255;
         if (expLast) begin
            mBusy = 1'b0;
            mPtr  = (mId + 1) % 4;
         end
      end
   endtask

   // Drive one cycle of inputs with fresh random data, check mid-cycle, step to the next cycle.
   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic r);
      ifA.i_req_valid = v;
      ifA.i_req_last  = l;
      ifA.i_ready     = r;
      for (int k = 0; k < 4; k++) ifA.i_req_data[k*32 +: 32] = $urandom;
      @(negedge i_clk);
      modelCheck();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [3:0] rv;
      logic [3:0] rl;
      logic       rr;
      logic [6:0] bpReady;
      total = 0;
      bad   = 0;
      modelReset();
      i_reset         = 1'b0;
      ifA.i_req_valid = '0;
      ifA.i_req_last  = '0;
      ifA.i_req_data  = '0;
      ifA.i_ready     = 1'b0;
      ifB.i_req_valid = '0;
      ifB.i_req_last  = '0;
      ifB.i_req_data  = '0;
      ifB.i_ready     = 1'b0;
      #1;
      doReset();

      // Basic grant: requester 2, three beats, then the pointer sits at 3.
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("basic_beats", 64'(ifA.o_beats), 64'd3);
      checkOutput("basic_id",    64'(ifA.o_id), 64'd2);
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkOutput("basic_ptr3",  64'(ifA.o_id), 64'd3);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Fairness: everyone requests single-beat bursts.
      doReset();
      for (int i = 0; i < 10; i++) applyStimulus(4'b1111, 4'b1111, 1'b1);

      // Backpressure on requester 1: four transfers spread over seven cycles.
      doReset();
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      bpReady = 7'b1011001;
      for (int i = 0; i < 7; i++) applyStimulus(4'b0010, (i == 6) ? 4'b0010 : 4'b0000, bpReady[i]);
      checkOutput("bp_beats", 64'(ifA.o_beats), 64'd4);

      // Lock: requester 3 raises valid during requester 0's burst.
      doReset();
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      applyStimulus(4'b1001, 4'b0000, 1'b1);
      applyStimulus(4'b1001, 4'b0000, 1'b1);
      applyStimulus(4'b1001, 4'b0001, 1'b1);
      applyStimulus(4'b1000, 4'b0000, 1'b1);
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Reset during beat 2 of requester 2's burst, then 0 beats 2 from a fresh pointer.
      doReset();
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      ifA.i_req_valid = 4'b0100;
      ifA.i_req_last  = 4'b0000;
      ifA.i_ready     = 1'b1;
      #2;
      i_reset = 1'b1;
      #1;
      checkResetValues();
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      modelReset();
      applyStimulus(4'b0101, 4'b0000, 1'b1);
      applyStimulus(4'b0101, 4'b0001, 1'b1);
      checkOutput("midrst_id", 64'(ifA.o_id), 64'd0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         rv = 4'($urandom);
         rl = 4'($urandom) & 4'($urandom);
         rr = ($urandom_range(0, 3) != 0);
         applyStimulus(rv, rl, rr);
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Narrow instance: six-beat burst from requester 2 saturates at 3, pointer wraps to 0.
      doReset();
      ifA.i_req_valid = '0;
      ifB.i_req_valid = 3'b100;
      ifB.i_req_last  = 3'b000;
      ifB.i_req_data  = 24'hAB_CD_EF;
      ifB.i_ready     = 1'b1;
      @(posedge i_clk);
      #1;
      checkOutput("sat_busy0", 64'(ifB.o_busy), 64'd1);
      checkOutput("sat_id",    64'(ifB.o_id), 64'd2);
      checkOutput("sat_beats0", 64'(ifB.o_beats), 64'd0);
      for (int k = 1; k <= 6; k++) begin
         ifB.i_req_last = (k == 6) ? 3'b100 : 3'b000;
         @(negedge i_clk);
         checkOutput("sat_valid", 64'(ifB.o_valid), 64'd1);
         checkOutput("sat_data",  64'(ifB.o_data), 64'hAB);
         @(posedge i_clk);
         #1;
         checkOutput("sat_beats", 64'(ifB.o_beats), 64'((k < 3) ? k : 3));
         checkOutput("sat_busy",  64'(ifB.o_busy), 64'((k < 6) ? 1 : 0));
      end
      ifB.i_req_valid = 3'b101;
      ifB.i_req_last  = 3'b001;
      @(posedge i_clk);
      #1;
      checkOutput("wrap_busy", 64'(ifB.o_busy), 64'd1);
      checkOutput("wrap_id",   64'(ifB.o_id), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_pal_arb.md
Name: pipe_pal_arb

Overview:
- Round-robin arbiter and sequencer that shares one W_DATA-wide pipe_pal datapath input among N_REQ requesters.
- Each requester presents packets as valid/ready bursts terminated by a last flag.
- The arbiter locks a grant for a whole burst, forwards the beats, and rotates priority after each burst.
- It sits directly in front of the shared datapath and exposes grant id, busy status and a beat counter for the downstream logic.

Parameters:
- W_DATA, 32, data width per beat.
- N_REQ, 4, number of requesters (2..16).
- W_ID, 2, grant id width; must satisfy 2**W_ID >= N_REQ.
- W_CNT, 8, width of burst beat counter.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req_valid  input  N_REQ  per-requester beat valid.
- i_req_data  input  N_REQ*W_DATA  per-requester data; requester k occupies bits [k*W_DATA +: W_DATA].
- i_req_last  input  N_REQ  per-requester last-beat flag.
- o_req_ready  output  N_REQ  per-requester ready.
- o_valid  output  1  beat valid to datapath.
- o_data  output  W_DATA  beat data to datapath.
- o_last  output  1  last beat of burst.
- o_id  output  W_ID  index of the granted requester.
- i_ready  input  1  datapath ready.
- o_busy  output  1  high while a burst is granted.
- o_beats  output  W_CNT  beats transferred in the current burst (saturating).

Behaviour:
- Clock and reset: single clock i_clk; reset is asynchronous, active-high on i_reset.
- Reset values: state=IDLE, priority pointer=0, grant=0, o_id=0, o_busy=0, o_beats=0, o_valid=0, o_last=0, o_data=0, o_req_ready=0.
- IDLE state:
  - o_valid=0 and o_req_ready=0.
  - If any i_req_valid bit is set, choose the first set bit scanning ptr, ptr+1, ... with wrap modulo N_REQ.
  - Register the choice into grant/o_id, clear o_beats, and go to BURST on the next edge.
  - Arbitration latency: one cycle from valid to first possible transfer.
- BURST state, combinational pass-through from the granted requester g:
  - o_valid = i_req_valid[g], o_data = data[g], o_last = i_req_last[g].
  - o_req_ready[g] = i_ready; all other o_req_ready bits = 0.
  - Non-granted data is never forwarded; o_data = 0 when o_valid = 0.
- Transfer: a beat transfers when o_valid && i_ready.
  - Each transfer increments o_beats, saturating at 2**W_CNT-1.
- Burst end: a transfer with o_last=1 ends the burst.
  - Next edge: state=IDLE, ptr=(g+1) mod N_REQ, o_busy=0.
  - o_beats and o_id hold their final values until the next grant.
  - There is always one IDLE bubble cycle between bursts.
- Grant lock: requests arriving or dropping from other requesters during BURST have no effect.
  - The granted requester may deassert valid mid-burst; the grant is held indefinitely until its last beat.
- Single-beat burst: valid and last on the first BURST cycle transfers one beat; o_beats=1.
- N_REQ not a power of two: the pointer wraps from N_REQ-1 to 0. Index values >= N_REQ are never generated.
- Reset mid-burst: the burst is abandoned immediately.
  - All outputs return to reset values asynchronously; ptr=0.
  - The partially sent packet is not resumed.
- o_busy=1 exactly while state=BURST.

Test Plan:
- Basic grant: reset, then i_req_valid=4'b0100 with a 3-beat burst (last on beat 3), i_ready=1 -> o_id=2 one cycle later; three transfers; o_beats=3; IDLE on the cycle after last; ptr=3.
- Fairness: all four requesters hold valid with single-beat bursts from reset -> grant order 0,1,2,3,0; each grant separated by exactly one idle cycle.
- Backpressure: granted requester 1 sends 4 beats while i_ready toggles 1,0,0,1,1,0,1 -> only ready-high cycles transfer; o_req_ready[1] follows i_ready; o_beats=4; data order preserved.
- Lock: requester 0 is in a burst when requester 3 raises valid -> o_req_ready[3] stays 0 until requester 0's last beat; requester 3 is then granted after one idle cycle.
- Reset mid-burst: assert i_reset during beat 2 of a 5-beat burst from requester 2 -> o_valid=0, o_busy=0, o_beats=0, o_id=0 immediately; after release, requester 0 wins over requester 2 when both request.
- Saturation and wrap: N_REQ=3, W_CNT=2, a 6-beat burst from requester 2 -> o_beats saturates at 3; next ptr=0.
